csi2tx_buf_rd_scheduler: RTL and testbench

CSI2TX_BUF_RD_SCHEDULER -- requirements
Module: csi2tx_buf_rd_scheduler

---
 rtl/csi2tx_buf_rd_scheduler.sv | 122 ++++++++++++
 tb/tb_csi2tx_buf_rd_scheduler.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2tx_buf_rd_scheduler.sv
// csi2tx_buf_rd_scheduler: arbitrates burst reads from per-VC sync buffers into one word stream.
// Define CSI2TX_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
`timescale 1ns/1ps
module csi2tx_buf_rd_scheduler #(
    parameter int NUM_CH          = 4,
    parameter int DATA_SIZE       = 64,
    parameter int FIFO_ADDR_WIDTH = 3,
    parameter int BURST_LEN       = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CH-1:0]                    buf_empty,
    input  logic [NUM_CH*(FIFO_ADDR_WIDTH+1)-1:0] buf_spacefilled,
    input  logic [NUM_CH*DATA_SIZE-1:0]          buf_rddata,
    input  logic [NUM_CH-1:0]                    buf_rddata_vld,
    output logic [NUM_CH-1:0]                    buf_rden,
    output logic [NUM_CH-1:0]                    buf_clr,
    input  logic                                 out_ready,
    output logic [DATA_SIZE-1:0]                 out_data,
    output logic                                 out_vld,
    output logic                                 out_last,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    input  logic                                 flush,
    output logic [NUM_CH-1:0]                    grant,
    output logic                                 busy
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int SW = FIFO_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [NUM_CH-1:0] grant_nxt;
    logic [CW-1:0]     gidx, gidx_nxt, win;
    logic [BW-1:0]     cnt, cnt_nxt;
    logic [SW-1:0]     sf_g;
    logic              rd, term;
`ifndef CSI2TX_SCHED_FIXED_PRIO_EN
    logic [CW-1:0]     ptr, ptr_nxt;
`endif

    // Descending scan so the last hit, the highest-priority candidate, wins.
    always_comb begin
        win = '0;
`ifdef CSI2TX_SCHED_FIXED_PRIO_EN
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (!buf_empty[i]) win = CW'(i);
`else
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (!buf_empty[(int'(ptr) + i) % NUM_CH]) win = CW'((int'(ptr) + i) % NUM_CH);
`endif
    end

    assign sf_g     = buf_spacefilled[gidx*SW +: SW];
    assign rd       = (state == BURST) && out_ready && !buf_empty[gidx] && !flush;
    assign term     = rd && ((cnt == BW'(BURST_LEN - 1)) || (sf_g == SW'(1)));
    assign busy     = (state != IDLE);
    assign buf_rden = rd ? grant : '0;
    assign buf_clr  = {NUM_CH{flush && rst_n}};
    // Grant is held through DRAIN so the terminal word still muxes out.
    assign out_vld  = busy && !flush && buf_rddata_vld[gidx];
    assign out_data = busy ? buf_rddata[gidx*DATA_SIZE +: DATA_SIZE] : '0;
    assign out_last = (state == DRAIN) && out_vld;
    assign out_ch   = gidx;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        gidx_nxt  = gidx;
        cnt_nxt   = cnt;
`ifndef CSI2TX_SCHED_FIXED_PRIO_EN
        ptr_nxt   = ptr;
`endif
        if (flush) begin
            state_nxt = IDLE;
            grant_nxt = '0;
            gidx_nxt  = '0;
            cnt_nxt   = '0;
`ifndef CSI2TX_SCHED_FIXED_PRIO_EN
            ptr_nxt   = '0;
`endif
        end else if (state == IDLE) begin
            if (|(~buf_empty)) begin
                state_nxt = BURST;
                grant_nxt = NUM_CH'(1) << win;
                gidx_nxt  = win;
                cnt_nxt   = '0;
            end
        end else if (state == BURST) begin
            if (rd) cnt_nxt = cnt + 1'b1;
            if (term) state_nxt = DRAIN;
        end else begin
            state_nxt = IDLE;
            grant_nxt = '0;
            gidx_nxt  = '0;
`ifndef CSI2TX_SCHED_FIXED_PRIO_EN
            ptr_nxt   = CW'((int'(gidx) + 1) % NUM_CH);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= '0;
            gidx  <= '0;
            cnt   <= '0;
`ifndef CSI2TX_SCHED_FIXED_PRIO_EN
            ptr   <= '0;
`endif
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            gidx  <= gidx_nxt;
            cnt   <= cnt_nxt;
`ifndef CSI2TX_SCHED_FIXED_PRIO_EN
            ptr   <= ptr_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_csi2tx_buf_rd_scheduler.sv
// tb_csi2tx_buf_rd_scheduler: randomized scoreboard bench against a transaction-level arbiter model.
`timescale 1ns/1ps
module tb_csi2tx_buf_rd_scheduler;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int FA = 3;
    localparam int BL = 4;
    localparam int SW = FA + 1;
    localparam int CW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] ch;
        logic          last;
    } exp_t;

    logic              clk, rst_n, out_ready, flush, out_vld, out_last, busy;
    logic [N-1:0]      buf_empty, buf_rddata_vld, buf_rden, buf_clr, grant;
    logic [N*SW-1:0]   buf_spacefilled;
    logic [N*DW-1:0]   buf_rddata;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ch;

    exp_t              sb[$];
    logic [DW-1:0]     bq[N][$];
    logic [DW-1:0]     mq[N][$];
    int                mptr;
    int                checks, errors;
    logic              rand_rdy, rdy_val;
    logic [N-1:0]      bm_rd, bm_clr, prev_rden, prev_grant, rmask;
    logic              prev_flush, prev_rst;
    exp_t              e;

    csi2tx_buf_rd_scheduler #(.NUM_CH(N), .DATA_SIZE(DW), .FIFO_ADDR_WIDTH(FA), .BURST_LEN(BL)) dut (
        .clk(clk), .rst_n(rst_n), .buf_empty(buf_empty), .buf_spacefilled(buf_spacefilled),
        .buf_rddata(buf_rddata), .buf_rddata_vld(buf_rddata_vld), .buf_rden(buf_rden),
        .buf_clr(buf_clr), .out_ready(out_ready), .out_data(out_data), .out_vld(out_vld),
        .out_last(out_last), .out_ch(out_ch), .flush(flush), .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync buffers: 1-cycle read latency, clear on buf_clr.
    initial begin
        buf_empty = '1; buf_spacefilled = '0; buf_rddata = '0; buf_rddata_vld = '0;
        forever begin
            @(negedge clk);
            bm_rd = buf_rden;
            bm_clr = buf_clr;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                buf_rddata_vld[k] = 1'b0;
                if (bm_clr[k]) bq[k].delete();
                else if (bm_rd[k] && bq[k].size() > 0) begin
                    buf_rddata[k*DW +: DW] = bq[k].pop_front();
                    buf_rddata_vld[k] = 1'b1;
                end
                buf_empty[k] = (bq[k].size() == 0);
                buf_spacefilled[k*SW +: SW] = SW'(bq[k].size());
            end
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
        end
    end

    // Bursts in arbitration order from a snapshot of the buffer contents.
    function automatic void predict();
        int k, n, c;
        while (1) begin
            k = -1;
`ifdef CSI2TX_SCHED_FIXED_PRIO_EN
            for (int i = 0; i < N; i++)
                if (k < 0 && mq[i].size() != 0) k = i;
`else
            for (int i = 0; i < N; i++) begin
                c = (mptr + i) % N;
                if (k < 0 && mq[c].size() != 0) k = c;
            end
`endif
            if (k < 0) break;
            n = (mq[k].size() < BL) ? mq[k].size() : BL;
            for (int j = 0; j < n; j++) sb.push_back({mq[k].pop_front(), CW'(k), j == n - 1});
            mptr = (k + 1) % N;
        end
    endfunction

    task automatic load(input int ch, input int n);
        logic [DW-1:0] w;
        for (int j = 0; j < n; j++) begin
            w = {$urandom, $urandom};
            bq[ch].push_back(w);
            mq[ch].push_back(w);
        end
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            bq[k].delete();
            mq[k].delete();
        end
        sb.delete();
        mptr = 0;
    endtask

    task automatic wait_idle();
        bit all_empty;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            all_empty = 1'b1;
            for (int k = 0; k < N; k++) if (bq[k].size() != 0) all_empty = 1'b0;
            if (!busy && grant == 0 && sb.size() == 0 && all_empty) return;
        end
        $display("FAIL idle_timeout busy=%0b pending=%0d want idle with 0 pending", busy, sb.size());
        $fatal(1, "timeout");
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (grant != 0) return;
        end
        $display("FAIL grant_timeout got grant=%b want nonzero", grant);
        $fatal(1, "timeout");
    endtask

    // Monitor: protocol rules every cycle, scoreboard pop on every out_vld.
    initial begin
        checks = 0; errors = 0;
        prev_rden = '0; prev_grant = '0; prev_flush = 1'b0; prev_rst = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                checks++;
                if ({grant, busy, buf_rden, buf_clr, out_vld, out_last, out_data, out_ch} != '0) begin
                    errors++;
                    $display("FAIL reset_outputs got grant=%b busy=%b rden=%b clr=%b vld=%b last=%b data=%h ch=%0d want all 0",
                             grant, busy, buf_rden, buf_clr, out_vld, out_last, out_data, out_ch);
                end
                prev_rden = '0; prev_grant = '0; prev_flush = 1'b0; prev_rst = 1'b1;
            end else begin
                rmask = (out_ready && !flush) ? grant : '0;
                checks++;
                if ((buf_rden & ~rmask) != 0) begin
                    errors++;
                    $display("FAIL rden_gating got rden=%b want subset of %b", buf_rden, rmask);
                end
                checks++;
                if (buf_clr != (flush ? {N{1'b1}} : {N{1'b0}})) begin
                    errors++;
                    $display("FAIL clr got %b want %b", buf_clr, flush ? {N{1'b1}} : {N{1'b0}});
                end
                checks++;
                if (out_vld != (prev_rden != 0 && !flush)) begin
                    errors++;
                    $display("FAIL vld_latency got out_vld=%b want %b", out_vld, prev_rden != 0 && !flush);
                end
                if (prev_flush || prev_rst) begin
                    checks++;
                    if (grant != 0 || busy) begin
                        errors++;
                        $display("FAIL idle_after_abort got grant=%b busy=%b want 0 0", grant, busy);
                    end
                end
                if (prev_grant == 0 && grant != 0 && out_ready && !flush) begin
                    checks++;
                    if (buf_rden != grant) begin
                        errors++;
                        $display("FAIL first_rden got rden=%b want %b", buf_rden, grant);
                    end
                end
                if (out_vld) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word got data=%h ch=%0d want none", out_data, out_ch);
                    end else begin
                        e = sb.pop_front();
                        if ({out_data, out_ch, out_last} != e) begin
                            errors++;
                            $display("FAIL word got data=%h ch=%0d last=%b want data=%h ch=%0d last=%b",
                                     out_data, out_ch, out_last, e.d, e.ch, e.last);
                        end
                    end
                end else begin
                    checks++;
                    if (out_last) begin
                        errors++;
                        $display("FAIL last_without_vld got out_last=1 want 0");
                    end
                end
                prev_rden = buf_rden; prev_grant = grant; prev_flush = flush; prev_rst = 1'b0;
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; rand_rdy = 1'b0; rdy_val = 1'b1; mptr = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b1;
        // Single short burst on ch0
        @(negedge clk); load(0, 3); predict(); wait_idle();
        // Two full channels alternate in BURST_LEN chunks
        @(negedge clk); load(1, 8); load(2, 8); predict(); wait_idle();
        @(negedge clk); load(0, 8); load(3, 8); predict(); wait_idle();
        // Two-cycle ready stall mid-burst
        @(negedge clk); load(2, 6); predict();
        wait_grant();
        @(negedge clk); rdy_val = 1'b0;
        @(negedge clk);
        @(negedge clk); rdy_val = 1'b1;
        wait_idle();
        rand_rdy = 1'b1;
        for (int r = 0; r < 25; r++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if ($urandom_range(0, 1) == 1) load(k, $urandom_range(1, 8));
            predict();
            wait_idle();
        end
        rand_rdy = 1'b0;
        // Flush in the second burst cycle, then pointer must restart at 0
        @(negedge clk); load(1, 1); predict(); wait_idle();
        @(negedge clk); load(3, 8); predict();
        wait_grant();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        clear_all();
        @(negedge clk); load(0, 2); load(3, 2); predict(); wait_idle();
        // Asynchronous reset mid-burst
        @(negedge clk); load(1, 8); predict();
        wait_grant();
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk); clear_all();
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk); load(0, 2); load(2, 5); load(3, 1); predict(); wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
